// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: BLOCK-bit lookahead groups, a register rank every
// BLOCKS_PER_STAGE groups, operand skew / sum deskew, and a valid/ready handshake on both sides.
module cla_pipe_adder #(
  parameter int WIDTH            = 32,
  parameter int BLOCK            = 4,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int SW   = BLOCK * BLOCKS_PER_STAGE;
  localparam int NSTG = WIDTH / SW;
  // Rank k holds {b slices k.., a slices k.., sum slices ..k-1}: 2*WIDTH - k*SW bits, packed back to back.
  localparam int TOT  = NSTG * 2 * WIDTH - SW * NSTG * (NSTG - 1) / 2;

  logic             adv;
  logic [TOT-1:0]   pipe_reg, pipe_next;
  logic [NSTG-1:0]  v_reg, v_next, c_reg, c_next;
  logic [WIDTH-1:0] res_next;
  logic             cout_next, ovf_next;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  assign pipe_next[0 +: WIDTH]     = in_a;
  assign pipe_next[WIDTH +: WIDTH] = in_sub ? ~in_b : in_b;
  assign c_next[0]                 = in_sub | in_cin;
  assign v_next[0]                 = in_valid;

  for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
    localparam int LO  = gi * SW;
    localparam int OW  = WIDTH - LO;
    localparam int OFF = gi * 2 * WIDTH - SW * gi * (gi - 1) / 2;

    logic [OW-1:0]    a_hi, b_hi;
    logic [SW-1:0]    g, p, s;
    logic [SW:0]      c;
    logic [LO+SW-1:0] done;

    assign a_hi = pipe_reg[OFF+LO +: OW];
    assign b_hi = pipe_reg[OFF+LO+OW +: OW];
    assign g    = a_hi[SW-1:0] & b_hi[SW-1:0];
    assign p    = a_hi[SW-1:0] ^ b_hi[SW-1:0];

    // Each group's recurrence flattens to lookahead; group carry-outs chain into the next group.
    always_comb begin
      c    = '0;
      c[0] = c_reg[gi];
      for (int gb = 0; gb < BLOCKS_PER_STAGE; gb++) begin
        for (int gk = 0; gk < BLOCK; gk++) begin
          c[gb*BLOCK+gk+1] = g[gb*BLOCK+gk] | (p[gb*BLOCK+gk] & c[gb*BLOCK+gk]);
        end
      end
    end

    assign s = p ^ c[SW-1:0];

    if (gi == 0) begin : g_first
      assign done = s;
    end else begin : g_rest
      assign done = {s, pipe_reg[OFF +: LO]};
    end

    if (gi < NSTG - 1) begin : g_fwd
      localparam int OFF1 = (gi + 1) * 2 * WIDTH - SW * (gi + 1) * gi / 2;
      assign pipe_next[OFF1 +: LO+SW]              = done;
      assign pipe_next[OFF1+LO+SW +: OW-SW]        = a_hi[OW-1:SW];
      assign pipe_next[OFF1+LO+SW+OW-SW +: OW-SW]  = b_hi[OW-1:SW];
      assign c_next[gi+1]                          = c[SW];
      assign v_next[gi+1]                          = v_reg[gi];
    end else begin : g_last
      assign res_next  = done;
      assign cout_next = c[SW];
      assign ovf_next  = c[SW] ^ c[SW-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_reg  <= '0;
      v_reg     <= '0;
      c_reg     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (adv) begin
      pipe_reg  <= pipe_next;
      v_reg     <= v_next;
      c_reg     <= c_next;
      out_valid <= v_reg[NSTG-1];
      out_sum   <= res_next;
      out_cout  <= cout_next;
      out_ovf   <= ovf_next;
      out_zero  <= (res_next == '0);
    end
  end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed arithmetic/stall/reset cases on the default build, and
// randomized streams on three builds against a queue-based arithmetic reference.
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        v32, r32, cin32, sub32, or32, ov32, co32, of32, z32;
  logic [31:0] a32, b32, s32;
  logic        v8, r8, cin8, sub8, or8, ov8, co8, of8, z8;
  logic [7:0]  a8, b8, s8;
  logic        v64, r64, cin64, sub64, or64, ov64, co64, of64, z64;
  logic [63:0] a64, b64, s64;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          age;
  } beat_t;

  cla_pipe_adder dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .in_a(a32), .in_b(b32),
    .in_cin(cin32), .in_sub(sub32), .out_valid(ov32), .out_ready(or32), .out_sum(s32),
    .out_cout(co32), .out_ovf(of32), .out_zero(z32));

  cla_pipe_adder #(.WIDTH(8), .BLOCK(4), .BLOCKS_PER_STAGE(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8),
    .in_cin(cin8), .in_sub(sub8), .out_valid(ov8), .out_ready(or8), .out_sum(s8),
    .out_cout(co8), .out_ovf(of8), .out_zero(z8));

  cla_pipe_adder #(.WIDTH(64), .BLOCK(4), .BLOCKS_PER_STAGE(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64), .in_a(a64), .in_b(b64),
    .in_cin(cin64), .in_sub(sub64), .out_valid(ov64), .out_ready(or64), .out_sum(s64),
    .out_cout(co64), .out_ovf(of64), .out_zero(z64));

  // Plain-arithmetic reference: w-bit add/sub with unsigned carry and signed overflow rules.
  function automatic beat_t ref_beat(input int w, input logic [63:0] a, input logic [63:0] b,
                                     input logic cin, input logic sub);
    beat_t       r;
    logic [63:0] m, be;
    logic [64:0] full;
    m      = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    be     = (sub ? ~b : b) & m;
    full   = {1'b0, a & m} + {1'b0, be} + {64'd0, (sub | cin)};
    r.sum  = full[63:0] & m;
    r.cout = full[w];
    r.ovf  = (a[w-1] == be[w-1]) && (r.sum[w-1] != a[w-1]);
    r.age  = 0;
    return r;
  endfunction

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    v32 = 1'b1; a32 = a; b32 = b; cin32 = cin; sub32 = sub;
    @(negedge clk);
    v32 = 1'b0;
  endtask

  task automatic wait_out32(output int lat);
    lat = 0;
    while (!ov32 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    v32 = 0; v8 = 0; v64 = 0; or32 = 1; or8 = 1; or64 = 1;
    a32 = '0; b32 = '0; cin32 = 0; sub32 = 0;
    a8 = '0; b8 = '0; cin8 = 0; sub8 = 0;
    a64 = '0; b64 = '0; cin64 = 0; sub64 = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ov32, s32, co32, of32, z32} !== 36'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b zero=%b, expected all zero",
               ov32, s32, co32, of32, z32);
    end
    n_cmp++;
    if ({r32, r8, r64} !== 3'b111) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b%b%b, expected 111", r32, r8, r64);
    end
    n_cmp++;
    if ({ov8, ov64} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_valid_other: got %b%b, expected 00", ov8, ov64);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({r32, ov32} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1/0", r32, ov32);
    end
    $display("[reset] outputs cleared, in_ready high");
  endtask

  task automatic test_add;
    logic [31:0] ta[3], tb[3], ts[3];
    logic        tc[3], tco[3], tov[3], tz[3];
    int          lat;
    ta  = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h12345678};
    tb  = '{32'h00000001, 32'h00000001, 32'h0FEDCBA9};
    tc  = '{1'b0, 1'b0, 1'b1};
    ts  = '{32'h00000000, 32'h80000000, 32'h22222222};
    tco = '{1'b1, 1'b0, 1'b0};
    tov = '{1'b0, 1'b1, 1'b0};
    tz  = '{1'b1, 1'b0, 1'b0};
    or32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send32(ta[i], tb[i], tc[i], 1'b0);
      wait_out32(lat);
      $display("[add] a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b zero=%b lat=%0d",
               ta[i], tb[i], tc[i], s32, co32, of32, z32, lat);
      n_cmp++;
      if (lat !== 4) begin
        n_err++;
        $display("FAIL add_latency[%0d]: got %0d cycles, expected 4", i, lat);
      end
      n_cmp++;
      if ({s32, co32, of32, z32} !== {ts[i], tco[i], tov[i], tz[i]}) begin
        n_err++;
        $display("FAIL add_result[%0d]: got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b zero=%b",
                 i, s32, co32, of32, z32, ts[i], tco[i], tov[i], tz[i]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sub;
    logic [31:0] ta[3], tb[3], ts[3];
    logic        tco[3], tov[3], tz[3];
    int          lat;
    ta  = '{32'h00000005, 32'h80000000, 32'h0000000A};
    tb  = '{32'h00000007, 32'h00000001, 32'h0000000A};
    ts  = '{32'hFFFFFFFE, 32'h7FFFFFFF, 32'h00000000};
    tco = '{1'b0, 1'b1, 1'b1};
    tov = '{1'b0, 1'b1, 1'b0};
    tz  = '{1'b0, 1'b0, 1'b1};
    or32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send32(ta[i], tb[i], 1'b1, 1'b1);
      wait_out32(lat);
      $display("[sub] a=%h b=%h -> sum=%h cout=%b ovf=%b zero=%b lat=%0d",
               ta[i], tb[i], s32, co32, of32, z32, lat);
      n_cmp++;
      if (lat !== 4) begin
        n_err++;
        $display("FAIL sub_latency[%0d]: got %0d cycles, expected 4", i, lat);
      end
      n_cmp++;
      if ({s32, co32, of32, z32} !== {ts[i], tco[i], tov[i], tz[i]}) begin
        n_err++;
        $display("FAIL sub_result[%0d]: got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b zero=%b",
                 i, s32, co32, of32, z32, ts[i], tco[i], tov[i], tz[i]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] got[$];
    int          got_cyc[$];
    int          cyc, stall;
    logic [31:0] held;
    held  = '0;
    cyc   = 0;
    stall = 0;
    or32  = 1'b1;
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          logic acc;
          acc = 1'b0;
          v32 = 1'b1; a32 = 32'(i); b32 = 32'(i) << 8; cin32 = 1'b0; sub32 = 1'b0;
          for (int k = 0; k < 50 && !acc; k++) begin
            #1;
            acc = r32;
            @(negedge clk);
          end
        end
        v32 = 1'b0;
      end
      begin
        while (got.size() < 8 && cyc < 60) begin
          or32 = !(got.size() == 2 && stall < 3);
          #1;
          if (!or32) begin
            stall++;
            n_cmp++;
            if (r32 !== 1'b0) begin
              n_err++;
              $display("FAIL stall_in_ready: got %b, expected 0 (stall cycle %0d)", r32, stall);
            end
            if (stall == 1) begin
              held = s32;
            end else begin
              n_cmp++;
              if (s32 !== held || ov32 !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold: got sum=%h valid=%b, expected sum=%h valid=1", s32, ov32, held);
              end
            end
          end else if (ov32) begin
            got.push_back(s32);
            got_cyc.push_back(cyc);
            $display("[b2b] result %0d sum=%h cycle=%0d", got.size(), s32, cyc);
          end
          @(negedge clk);
          cyc++;
        end
        or32 = 1'b1;
      end
    join
    n_cmp++;
    if (got.size() !== 8) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results, expected 8", got.size());
    end
    for (int j = 0; j < got.size() && j < 8; j++) begin
      n_cmp++;
      if (got[j] !== 32'h101 * 32'(j + 1)) begin
        n_err++;
        $display("FAIL b2b_order[%0d]: got %h, expected %h", j, got[j], 32'h101 * 32'(j + 1));
      end
    end
    for (int j = 3; j < got_cyc.size(); j++) begin
      n_cmp++;
      if (got_cyc[j] - got_cyc[j-1] !== 1) begin
        n_err++;
        $display("FAIL b2b_rate[%0d]: got gap %0d cycles, expected 1", j, got_cyc[j] - got_cyc[j-1]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midflight;
    int   lat;
    logic seen;
    or32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v32 = 1'b1; a32 = 32'h1000 + 32'(i); b32 = 32'h1; cin32 = 1'b0; sub32 = 1'b0;
      @(negedge clk);
    end
    v32 = 1'b0;
    wait_out32(lat);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ov32 !== 1'b0) begin
      n_err++;
      $display("FAIL midflight_async: got out_valid=%b during reset, expected 0", ov32);
    end
    #3;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ov32) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL midflight_discard: got out_valid=1 after reset, expected no stale results");
    end
    send32(32'hDEAD0000, 32'h0000BEEF, 1'b0, 1'b0);
    wait_out32(lat);
    $display("[rst] post-reset beat sum=%h lat=%0d", s32, lat);
    n_cmp++;
    if (lat !== 4 || s32 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL midflight_after: got sum=%h lat=%0d, expected sum=deadbeef lat=4", s32, lat);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random(input int sel, input int nbeats);
    beat_t       q[$];
    beat_t       e;
    int          w, nstg, sent, recv, cyc;
    logic        vin, ordy, cin, sub, ev, ovalid, ocout, oovf, ozero, ir;
    logic [63:0] a, b, m, osum;
    case (sel)
      0:       begin w = 32; nstg = 4; end
      1:       begin w = 8;  nstg = 2; end
      default: begin w = 64; nstg = 4; end
    endcase
    m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < nbeats && cyc < nbeats * 20) begin
      case (sel)
        0:       begin ovalid = ov32; osum = {32'd0, s32}; ocout = co32; oovf = of32; ozero = z32; end
        1:       begin ovalid = ov8;  osum = {56'd0, s8};  ocout = co8;  oovf = of8;  ozero = z8;  end
        default: begin ovalid = ov64; osum = s64;          ocout = co64; oovf = of64; ozero = z64; end
      endcase
      ev = (q.size() > 0) && (q[0].age == nstg);
      n_cmp++;
      if (ovalid !== ev) begin
        n_err++;
        $display("FAIL rnd_valid w=%0d cyc=%0d: got out_valid=%b, expected %b", w, cyc, ovalid, ev);
      end else if (ev) begin
        n_cmp++;
        if ({osum, ocout, oovf, ozero} !== {q[0].sum, q[0].cout, q[0].ovf, (q[0].sum == 64'd0)}) begin
          n_err++;
          $display("FAIL rnd_data w=%0d: got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b",
                   w, osum, ocout, oovf, ozero, q[0].sum, q[0].cout, q[0].ovf);
        end
      end
      vin  = (sent < nbeats) && ($urandom_range(3) != 0);
      a    = {$urandom, $urandom} & m;
      b    = {$urandom, $urandom} & m;
      cin  = 1'($urandom_range(1));
      sub  = 1'($urandom_range(1));
      ordy = ($urandom_range(3) != 0);
      case (sel)
        0:       begin v32 = vin; a32 = a[31:0]; b32 = b[31:0]; cin32 = cin; sub32 = sub; or32 = ordy; end
        1:       begin v8 = vin;  a8 = a[7:0];   b8 = b[7:0];   cin8 = cin;  sub8 = sub;  or8 = ordy;  end
        default: begin v64 = vin; a64 = a;       b64 = b;       cin64 = cin; sub64 = sub; or64 = ordy; end
      endcase
      #1;
      case (sel)
        0:       ir = r32;
        1:       ir = r8;
        default: ir = r64;
      endcase
      n_cmp++;
      if (ir !== (!ev | ordy)) begin
        n_err++;
        $display("FAIL rnd_in_ready w=%0d cyc=%0d: got %b, expected %b", w, cyc, ir, !ev | ordy);
      end
      if (!ev | ordy) begin
        if (ev) begin
          $display("[rnd w=%0d] beat %0d sum=%h cout=%b ovf=%b", w, recv, q[0].sum, q[0].cout, q[0].ovf);
          void'(q.pop_front());
          recv++;
        end
        foreach (q[i]) q[i].age = q[i].age + 1;
        if (vin) begin
          e = ref_beat(w, a, b, cin, sub);
          q.push_back(e);
          sent++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (recv !== nbeats) begin
      n_err++;
      $display("FAIL rnd_timeout w=%0d: got %0d beats, expected %0d", w, recv, nbeats);
    end
    v32 = 0; v8 = 0; v64 = 0; or32 = 1; or8 = 1; or64 = 1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_midflight();
    test_random(1, 10000);
    test_random(2, 10000);
    test_random(0, 2000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It is the multi-stage successor to the team's 4-bit CLA block.
- Operands are split into BLOCK-bit lookahead groups. Generate = A&B, propagate = A^B, and carry lookahead run inside each group.
- Carries ripple between groups. A pipeline register is placed every BLOCKS_PER_STAGE groups.
- A valid/ready handshake on both sides lets the block sit in ALU/datapath pipelines at WIDTH up to 64 without a long carry chain.

Parameters:
WIDTH, 32, operand and sum width in bits; must be a multiple of BLOCK*BLOCKS_PER_STAGE.
BLOCK, 4, bits per lookahead group.
BLOCKS_PER_STAGE, 2, lookahead groups evaluated per pipeline stage.
(Derived, not overridable) NSTG = WIDTH/(BLOCK*BLOCKS_PER_STAGE) is both the stage count and the latency.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept a beat this cycle.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_cin  input  1  carry-in; used only when in_sub=0.
in_sub  input  1  1 = compute A-B, 0 = compute A+B+cin.
out_valid  output  1  result beat valid.
out_ready  input  1  downstream accepts the result.
out_sum  output  WIDTH  result.
out_cout  output  1  carry out of the MSB; in sub mode, 1 = no borrow (A>=B unsigned).
out_ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
out_zero  output  1  1 when out_sum == 0.

Behaviour:
- Global advance: adv = !out_valid | out_ready. The whole pipeline shifts only when adv=1.
- in_ready = adv, purely combinational from out_valid/out_ready.
- Bubbles are not compressed.
- A beat is accepted when in_valid & in_ready.
- The result is delivered when out_valid & out_ready.
- Sub mode: the effective B is ~in_b and the effective carry-in is forced to 1. in_cin is ignored.
- Stage k (0..NSTG-1) computes sum slice k from:
  - the registered skewed operand slice k, and
  - the carry registered by stage k-1 (stage 0 uses the effective cin).
- Within a stage, each group uses full lookahead: c[i+1] = g[i] | p[i]&c[i] for each bit position i, and sum = p ^ c. Carry ripples between groups in the same stage.
- Operand skew: slice k is delayed k register stages before it is consumed.
- Result deskew: sum slice k is delayed NSTG-1-k stages, so all slices align at the output.
- The stage valid bit travels with the data.
- Latency: a beat accepted at edge t appears on out_* after edge t+NSTG, provided adv=1 on every intervening cycle. Stall cycles add to the latency 1:1.
- Throughput: 1 beat/cycle while out_ready=1.
- out_sum, out_cout, out_ovf and out_zero are registered in the final stage. out_zero is computed from the aligned sum before that register.
- Outputs are stable while out_valid=1 and out_ready=0, and must not change until the transfer completes.
- in_valid=0 with adv=1 inserts a bubble (valid=0) at stage 0.
- Ordering: strict FIFO. No beat is lost or duplicated across stalls.
- Reset (asynchronous assert, synchronous-to-clk deassert handled upstream):
  - All stage valid bits are cleared and all data registers go to 0.
  - Outputs: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0, in_ready=1.
  - Asserting reset mid-operation discards every in-flight beat. After release, the first output is the first beat accepted after reset.
- Width arithmetic: no internal truncation. The carry out of the top group is out_cout; the carry into the top bit feeds out_ovf.
- Simultaneous accept and deliver in the same cycle is legal. The pipeline shifts and occupancy is unchanged.

Test Plan:
1. Defaults (NSTG=4). in_a=0xFFFFFFFF, in_b=0x00000001, cin=0, sub=0, out_ready=1 -> out_sum=0x00000000, cout=1, ovf=0, zero=1, exactly 4 cycles after accept.
2. Add 0x7FFFFFFF+0x00000001 -> sum=0x80000000, cout=0, ovf=1, zero=0. Then add 0x12345678+0x0FEDCBA9 with cin=1 -> sum=0x22222222, cout=0, ovf=0.
3. Sub mode with cin=1 driven:
   - 0x00000005-0x00000007 -> 0xFFFFFFFE, cout=0, ovf=0.
   - 0x80000000-0x00000001 -> 0x7FFFFFFF, cout=1, ovf=1.
   - 0x0000000A-0x0000000A -> 0x00000000, cout=1, zero=1.
4. Stream 8 back-to-back beats (A=i, B=0x100*i, i=1..8) and drop out_ready for 3 cycles after the 2nd result -> in_ready=0 during the stall, out_* held steady, results 0x101*i in order with no loss or duplication, then 1 beat/cycle resumes.
5. Reset mid-flight: accept 3 beats, pulse rst_n low for half a cycle -> out_valid drops to 0 immediately (asynchronous) and none of the 3 results ever appears. A beat accepted after release emerges 4 cycles later.
6. Parameter sweep (WIDTH=8/BLOCKS_PER_STAGE=1 -> NSTG=2; WIDTH=64/BLOCKS_PER_STAGE=4 -> NSTG=4), 10k random beats with random sub/cin/out_ready -> sum, cout and ovf match the behavioural model, and latency equals NSTG plus stall cycles.
